// File: rtl/router_arp_lut.sv
// rtl/router_arp_lut.sv - ARP table: {next-hop IP, MAC} entries with a 2-stage lookup pipe
// and a level-request/pulse-ack read/write access port for the op-LUT register block.
module router_arp_lut #(
  parameter int ARP_LUT_DEPTH_BITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lookup_req,
  input  logic [31:0]                   lookup_ip,
  output logic                          lookup_ack,
  output logic                          lookup_hit,
  output logic [47:0]                   lookup_mac,
  input  logic [ARP_LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                          arp_rd_req,
  output logic [47:0]                   arp_rd_mac,
  output logic [31:0]                   arp_rd_ip,
  output logic                          arp_rd_ack,
  input  logic [ARP_LUT_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                          arp_wr_req,
  input  logic [47:0]                   arp_wr_mac,
  input  logic [31:0]                   arp_wr_ip,
  output logic                          arp_wr_ack
);

  localparam int DEPTH = 2 ** ARP_LUT_DEPTH_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ACK   = 2'd1,
    RD_ACK   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  logic [31:0] ip_tbl  [DEPTH];
  logic [47:0] mac_tbl [DEPTH];

  state_t      state;
  state_t      state_nxt;
  logic        svc_wr;
  logic        do_wr;
  logic        do_rd;

  logic        s0_valid;
  logic [31:0] s0_ip;
  logic        cmp_hit;
  logic [47:0] cmp_mac;

  // Walk from the top down so the lowest matching index is the one left standing.
  always_comb begin
    cmp_hit = 1'b0;
    cmp_mac = 48'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((ip_tbl[i] != 32'd0) && (ip_tbl[i] == s0_ip)) begin
        cmp_hit = 1'b1;
        cmp_mac = mac_tbl[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid   <= 1'b0;
      s0_ip      <= 32'd0;
      lookup_ack <= 1'b0;
      lookup_hit <= 1'b0;
      lookup_mac <= 48'd0;
    end else begin
      s0_valid   <= lookup_req;
      s0_ip      <= lookup_ip;
      lookup_ack <= s0_valid;
      if (s0_valid) begin
        lookup_hit <= cmp_hit;
        lookup_mac <= cmp_mac;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // svc_wr remembers which request was serviced so WAIT_REL only releases on that one.
  always_comb begin
    state_nxt = state;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (arp_wr_req) begin
          do_wr     = 1'b1;
          state_nxt = WR_ACK;
        end else if (arp_rd_req) begin
          do_rd     = 1'b1;
          state_nxt = RD_ACK;
        end
      end
      WR_ACK:   state_nxt = WAIT_REL;
      RD_ACK:   state_nxt = WAIT_REL;
      WAIT_REL: begin
        if (svc_wr ? !arp_wr_req : !arp_rd_req) begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      svc_wr     <= 1'b0;
      arp_wr_ack <= 1'b0;
      arp_rd_ack <= 1'b0;
      arp_rd_ip  <= 32'd0;
      arp_rd_mac <= 48'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ip_tbl[i]  <= 32'd0;
        mac_tbl[i] <= 48'd0;
      end
    end else begin
      arp_wr_ack <= (state == WR_ACK);
      arp_rd_ack <= (state == RD_ACK);
      if (do_wr) begin
        svc_wr               <= 1'b1;
        ip_tbl[arp_wr_addr]  <= arp_wr_ip;
        mac_tbl[arp_wr_addr] <= arp_wr_mac;
      end
      if (do_rd) begin
        svc_wr     <= 1'b0;
        arp_rd_ip  <= ip_tbl[arp_rd_addr];
        arp_rd_mac <= mac_tbl[arp_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_router_arp_lut.sv
// tb/tb_router_arp_lut.sv - directed and randomized checks of router_arp_lut against
// an array-based table model.
module tb_router_arp_lut;

  logic        clk;
  logic        reset;
  logic        lookup_req;
  logic [31:0] lookup_ip;
  logic        lookup_ack;
  logic        lookup_hit;
  logic [47:0] lookup_mac;
  logic [3:0]  arp_rd_addr;
  logic        arp_rd_req;
  logic [47:0] arp_rd_mac;
  logic [31:0] arp_rd_ip;
  logic        arp_rd_ack;
  logic [3:0]  arp_wr_addr;
  logic        arp_wr_req;
  logic [47:0] arp_wr_mac;
  logic [31:0] arp_wr_ip;
  logic        arp_wr_ack;

  router_arp_lut #(.ARP_LUT_DEPTH_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_ack(lookup_ack),
    .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac),
    .arp_rd_ip(arp_rd_ip), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac),
    .arp_wr_ip(arp_wr_ip), .arp_wr_ack(arp_wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_ip  [16];
  logic [47:0] ref_mac [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [48:0] ref_lookup(input logic [31:0] ip);
    for (int i = 0; i < 16; i++) begin
      if (ref_ip[i] != 32'd0 && ref_ip[i] == ip) return {1'b1, ref_mac[i]};
    end
    return 49'd0;
  endfunction

  function automatic logic [47:0] rand_mac();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      ref_ip[i]  = 32'd0;
      ref_mac[i] = 48'd0;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] ip, input logic [47:0] mac);
    arp_wr_addr = a; arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_req = 1'b1;
    tick();
    ref_ip[a] = ip; ref_mac[a] = mac;
    check("wr_ack_early", {63'd0, arp_wr_ack}, 64'd0);
    tick();
    check("wr_ack", {63'd0, arp_wr_ack}, 64'd1);
    arp_wr_req = 1'b0;
    tick();
    check("wr_ack_drop", {63'd0, arp_wr_ack}, 64'd0);
  endtask

  task automatic do_read(input logic [3:0] a);
    arp_rd_addr = a; arp_rd_req = 1'b1;
    tick();
    tick();
    check("rd_ack", {63'd0, arp_rd_ack}, 64'd1);
    check("rd_ip", {32'd0, arp_rd_ip}, {32'd0, ref_ip[a]});
    check("rd_mac", {16'd0, arp_rd_mac}, {16'd0, ref_mac[a]});
    arp_rd_req = 1'b0;
    tick();
    check("rd_ack_drop", {63'd0, arp_rd_ack}, 64'd0);
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] ip);
    logic [48:0] e;
    e = ref_lookup(ip);
    lookup_req = 1'b1; lookup_ip = ip;
    tick();
    lookup_req = 1'b0;
    check({tag, "_ack_early"}, {63'd0, lookup_ack}, 64'd0);
    tick();
    check({tag, "_ack"}, {63'd0, lookup_ack}, 64'd1);
    check({tag, "_hit"}, {63'd0, lookup_hit}, {63'd0, e[48]});
    check({tag, "_mac"}, {16'd0, lookup_mac}, {16'd0, e[47:0]});
    tick();
    check({tag, "_ack_drop"}, {63'd0, lookup_ack}, 64'd0);
  endtask

  logic [48:0] exp_q [$];
  logic [3:0]  hit_addrs [$];

  initial begin
    logic [48:0] e;
    logic [31:0] ip;
    logic [3:0]  a;
    int          waited;
    bit          got;

    clear_model();
    reset = 1'b0; lookup_req = 1'b0; lookup_ip = 32'd0;
    arp_rd_req = 1'b0; arp_rd_addr = 4'd0;
    arp_wr_req = 1'b0; arp_wr_addr = 4'd0; arp_wr_ip = 32'd0; arp_wr_mac = 48'd0;
    tick(); tick();
    check("rst_outputs", {lookup_ack, lookup_hit, arp_rd_ack, arp_wr_ack, 60'd0}, 64'd0);
    check("rst_data", {16'd0, lookup_mac ^ arp_rd_mac}, {16'd0, arp_rd_ip, 16'd0} & 64'd0);
    reset = 1'b1;
    tick();

    do_lookup("lk_empty", 32'h0A000001);
    do_write(4'd3, 32'h0A000001, 48'h001122334455);
    do_lookup("lk_hit3", 32'h0A000001);
    do_write(4'd2, 32'hC0A80001, 48'h0000000000AA);
    do_write(4'd5, 32'hC0A80001, 48'h0000000000BB);
    do_lookup("lk_dup", 32'hC0A80001);
    do_read(4'd5);
    do_lookup("lk_zero", 32'h0);

    // Random entries, then a back-to-back burst alternating hit and miss IPs.
    hit_addrs = '{4'd2, 4'd3, 4'd5};
    for (int k = 10; k < 14; k++) begin
      a = 4'(k);
      do_write(a, 32'h0C000000 | $urandom_range(1, 32'hFFFF), rand_mac());
      hit_addrs.push_back(a);
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        if (c % 2 == 0) ip = ref_ip[hit_addrs[$urandom_range(0, hit_addrs.size() - 1)]];
        else if (c == 1) ip = 32'd0;
        else ip = 32'hEE000000 | $urandom_range(0, 255);
        lookup_req = 1'b1; lookup_ip = ip;
        exp_q.push_back(ref_lookup(ip));
      end else begin
        lookup_req = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        e = exp_q.pop_front();
        check("burst_ack", {63'd0, lookup_ack}, 64'd1);
        check("burst_hit", {63'd0, lookup_hit}, {63'd0, e[48]});
        check("burst_mac", {16'd0, lookup_mac}, {16'd0, e[47:0]});
      end else if (c == 9) begin
        check("burst_ack_end", {63'd0, lookup_ack}, 64'd0);
      end
    end

    // Write and read raised together: write first, read after write request drops.
    arp_wr_addr = 4'd7; arp_wr_ip = 32'h01020304; arp_wr_mac = rand_mac(); arp_wr_req = 1'b1;
    arp_rd_addr = 4'd7; arp_rd_req = 1'b1;
    tick();
    ref_ip[7] = 32'h01020304; ref_mac[7] = arp_wr_mac;
    tick();
    check("both_wr_ack", {63'd0, arp_wr_ack}, 64'd1);
    check("both_rd_ack_low", {63'd0, arp_rd_ack}, 64'd0);
    arp_wr_req = 1'b0;
    got = 1'b0; waited = 0;
    while (!got && waited < 10) begin
      tick();
      waited++;
      if (arp_rd_ack) got = 1'b1;
    end
    check("both_rd_ack_seen", {63'd0, got}, 64'd1);
    check("both_rd_latency", 64'(waited), 64'd3);
    check("both_rd_ip", {32'd0, arp_rd_ip}, 64'h01020304);
    check("both_rd_mac", {16'd0, arp_rd_mac}, {16'd0, ref_mac[7]});
    arp_rd_req = 1'b0;
    tick();
    check("both_no_reack", {62'd0, arp_wr_ack, arp_rd_ack}, 64'd0);
    tick();

    // Compare edge coincides with the write commit edge.
    lookup_req = 1'b1; lookup_ip = 32'h0B0B0B0B;
    tick();
    arp_wr_addr = 4'd9; arp_wr_ip = 32'h0B0B0B0B; arp_wr_mac = 48'h0000DEADBEEF; arp_wr_req = 1'b1;
    tick();
    check("race_ack", {63'd0, lookup_ack}, 64'd1);
    check("race_miss", {63'd0, lookup_hit}, 64'd0);
    ref_ip[9] = 32'h0B0B0B0B; ref_mac[9] = 48'h0000DEADBEEF;
    e = ref_lookup(32'h0B0B0B0B);
    lookup_req = 1'b0;
    tick();
    check("race_next_ack", {63'd0, lookup_ack}, 64'd1);
    check("race_next_hit", {63'd0, lookup_hit}, {63'd0, e[48]});
    check("race_next_mac", {16'd0, lookup_mac}, {16'd0, e[47:0]});
    check("race_wr_ack", {63'd0, arp_wr_ack}, 64'd1);
    arp_wr_req = 1'b0;
    tick();

    // Reset mid-lookup drops the result and clears the table.
    lookup_req = 1'b1; lookup_ip = 32'h0A000001;
    tick();
    lookup_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outputs", {lookup_ack, lookup_hit, 62'd0}, 64'd0);
    check("rst_mid_mac", {16'd0, lookup_mac}, 64'd0);
    tick();
    reset = 1'b1;
    clear_model();
    tick();
    check("rst_mid_no_ack", {63'd0, lookup_ack}, 64'd0);
    tick();
    check("rst_mid_no_ack2", {63'd0, lookup_ack}, 64'd0);
    do_read(4'd3);
    do_lookup("lk_after_rst", 32'h0A000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
